cos_poly_eval: RTL
==================

// Module: cos_poly_eval
//
// PURPOSE
// Consumer side of the cosine coefficient ROM: accepts phase words, folds them to one
// quadrant, drives the ROM address, and evaluates y = c0 + c1*x on the returned
// coefficients. Sits between the uniform-phase source and the Box-Muller output
// multiplier. The ROM instance is outside this block; all of its ports are on this block.
// Output is buffered in a credit-controlled FIFO so downstream may stall freely.
//
// PARAMETERS
// XB          7   offset bits x below the ROM address (phase word = 2+7+XB bits)
// FIFO_DEPTH  4   output FIFO entries (power of 2, >= 4)
//
// PORTS
// clock      in   1      single clock, all logic on rising edge
// reset_n    in   1      synchronous reset, active low
// in_valid   in   1      phase word valid
// in_ready   out  1      block can accept a phase word this cycle
// in_u       in   9+XB   phase: [8+XB:7+XB] quadrant q, [6+XB:XB] addr a, [XB-1:0] offset x
// rom_addr   out  7      address to cosine ROM (ROM registers c1/c0 one edge later)
// rom_c1     in   12     ROM slope coefficient, unsigned
// rom_c0     in   19     ROM intercept coefficient, unsigned
// out_valid  out  1      out_y valid (FIFO not empty)
// out_ready  in   1      downstream accepts out_y
// out_y      out  20     signed result, two's complement
//
// BEHAVIOUR
// - Reset (reset_n=0 at edge): in_ready=0 during reset, 1 first cycle after; out_valid=0,
//   out_y=0, rom_addr=0; pipeline valids, in-flight count, FIFO pointers cleared. Reset
//   mid-operation discards all in-flight and buffered results.
// - Accept: transfer when in_valid && in_ready. in_ready = (fifo_count + inflight) < FIFO_DEPTH.
// - Fold: q in {1,3}: a' = 127-a, x' = (2^XB-1)-x; else a'=a, x'=x. Negate flag neg = (q==1||q==2).
// - Stage 0 (accept edge): rom_addr <= a'; x', neg, valid registered alongside.
// - Stage 1 (next edge): ROM presents c1/c0; x', neg delayed one edge to stay aligned.
// - Stage 2: p = c1*x' (12x7 -> 19b unsigned); m = c0 + (p >> XB); m is 20b; if m > 0x7FFFF
//   saturate to 0x7FFFF.
// - Stage 3: y = neg ? -{1'b0,m} : {1'b0,m}; written into FIFO.
// - Latency: accept edge to FIFO write = 3 edges; out_valid rises the cycle after write
//   (4 cycles total when FIFO empty). Throughput 1/cycle while out_ready=1.
// - Pipeline never stalls; credit rule guarantees FIFO never overflows. inflight counts
//   stage 0..3 valids; increments on accept, decrements on FIFO write, both same cycle = hold.
// - FIFO: out_y/out_valid from head; pop on out_valid && out_ready. Simultaneous push+pop
//   when full or empty is legal; count unchanged, order preserved. Pointers wrap mod depth.
// - out_y holds stable while out_valid && !out_ready. rom_addr holds last value when idle.
//
// CONFIGURATION
// AWGN_COS_ROUND_EN defined: stage 2 uses (p + 2^(XB-1)) >> XB (round half up), then saturate.
// Not defined: truncation (p >> XB). No other difference in latency or interface.
//
// TESTING (bench uses the cosine ROM model as rom_* responder)
// T1 reset: hold reset_n=0 5 cycles with in_valid=1 -> out_valid=0, no accept; release ->
//    in_ready=1 next cycle.
// T2 u=0x0000 (q0,a0,x0), out_ready=1 -> rom_addr=0, out_y=20'h40001 exactly 4 cycles after accept.
// T3 u=0x8000 (q2,a0,x0) -> out_y=20'hBFFFF; u=0x4000 (q1,a127,x127) -> out_y=20'hB210C.
// T4 out_ready=0, 6 back-to-back words -> exactly 4 accepted then in_ready=0; raise
//    out_ready -> 4 results in order, remaining 2 accepted, no loss or duplication.
// T5 u with a=1,x=127: truncate -> 0x40010+(0x012*127>>7)=0x40021; with AWGN_COS_ROUND_EN -> 0x40022.
// T6 reset_n pulsed low 1 cycle with 3 in flight and 2 buffered -> out_valid=0 after; next
//    input yields its own correct result only.

Source files
------------

// File: rtl/cos_poly_eval.sv
// cos_poly_eval: consumer side of the cosine coefficient ROM.
//
// Takes phase words and folds each into the first quadrant. It drives the external ROM
// address and evaluates y = c0 + c1*x on the coefficients the ROM returns. Results go into
// a small output FIFO. An input credit check makes sure the FIFO can never overflow, so the
// pipeline never has to stall.
//
// Optional build macro: AWGN_COS_ROUND_EN
//   defined   -> slope term is rounded half up: (c1*x + 2^(Xb-1)) >> Xb
//   undefined -> slope term is truncated:       (c1*x) >> Xb
//
// Ports:
//   clk_i        clock, all logic on the rising edge
//   rst_ni       synchronous reset, active low
//   in_valid_i   phase word valid
//   in_ready_o   a phase word can be accepted this cycle
//   in_u_i       phase word {quadrant[1:0], addr[6:0], offset[Xb-1:0]}
//   rom_addr_o   cosine ROM address (the ROM registers c1/c0 one edge later)
//   rom_c1_i     ROM slope coefficient, unsigned
//   rom_c0_i     ROM intercept coefficient, unsigned
//   out_valid_o  out_y_o holds a valid result (FIFO not empty)
//   out_ready_i  downstream accepts out_y_o
//   out_y_o      signed result, two's complement

module cos_poly_eval #(
  parameter int unsigned Xb        = 7,
  parameter int unsigned FifoDepth = 4
) (
  input  logic          clk_i,
  input  logic          rst_ni,
  input  logic          in_valid_i,
  output logic          in_ready_o,
  input  logic [8+Xb:0] in_u_i,
  output logic [6:0]    rom_addr_o,
  input  logic [11:0]   rom_c1_i,
  input  logic [18:0]   rom_c0_i,
  output logic          out_valid_o,
  input  logic          out_ready_i,
  output logic [19:0]   out_y_o
);

  localparam int unsigned PtrW = $clog2(FifoDepth);
  localparam int unsigned CntW = PtrW + 1;
  localparam int unsigned PW   = 12 + Xb;

  localparam logic [CntW:0] DepthCmp = (CntW + 1)'(FifoDepth);
`ifdef AWGN_COS_ROUND_EN
  localparam logic [PW-1:0] RoundInc = PW'(1) << (Xb - 1);
`endif

  // ---------------------------------------------------------------------------------------
  // Quadrant fold
  // ---------------------------------------------------------------------------------------
  logic [1:0]    quad;
  logic [6:0]    addr_raw, addr_fold;
  logic [Xb-1:0] x_raw, x_fold;
  logic          neg_in;

  assign quad     = in_u_i[8+Xb:7+Xb];
  assign addr_raw = in_u_i[6+Xb:Xb];
  assign x_raw    = in_u_i[Xb-1:0];

  // Odd quadrants run the curve backwards: 127-a and (2^Xb-1)-x are bitwise inverses.
  always_comb begin
    addr_fold = addr_raw;
    x_fold    = x_raw;
    if (quad[0]) begin
      addr_fold = ~addr_raw;
      x_fold    = ~x_raw;
    end
    // Cosine is negative in quadrants 1 and 2.
    neg_in = quad[0] ^ quad[1];
  end

  // ---------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------
  logic            in_ready_q, in_ready_d;
  logic [6:0]      rom_addr_q;
  logic [Xb-1:0]   x0_q, x1_q;
  logic            neg0_q, neg1_q, neg2_q;
  logic            v0_q, v1_q, v2_q;
  logic [18:0]     m2_q;
  logic [CntW-1:0] inflight_q, inflight_d;
  logic [CntW-1:0] count_q, count_d;
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [19:0]     mem_q [FifoDepth];

  logic accept, push, pop;

  assign accept = in_valid_i & in_ready_q;
  assign push   = v2_q;
  assign pop    = out_valid_o & out_ready_i;

  // ---------------------------------------------------------------------------------------
  // Stage 2 datapath: ROM coefficients (valid after the edge following stage 0) with x1_q
  // ---------------------------------------------------------------------------------------
  logic [PW-1:0]    prod, prod_adj;
  logic [PW-Xb-1:0] prod_sh;
  logic [19:0]      m_sum;
  logic [18:0]      m_sat;

  assign prod = PW'(rom_c1_i) * PW'(x1_q);
`ifdef AWGN_COS_ROUND_EN
  // Cannot overflow PW bits: the largest product is at least 2^Xb below 2^PW.
  assign prod_adj = prod + RoundInc;
`else
  assign prod_adj = prod;
`endif
  assign prod_sh = prod_adj[PW-1:Xb];
  assign m_sum   = 20'(rom_c0_i) + 20'(prod_sh);
  // The sum stays below 2^20, so bit 19 set means exactly m > 0x7FFFF.
  assign m_sat   = m_sum[19] ? 19'h7FFFF : m_sum[18:0];

  // ---------------------------------------------------------------------------------------
  // Stage 3: apply sign, feeds the FIFO write
  // ---------------------------------------------------------------------------------------
  logic [19:0] y_pos, y3;

  assign y_pos = {1'b0, m2_q};
  assign y3    = neg2_q ? (20'd0 - y_pos) : y_pos;

  // ---------------------------------------------------------------------------------------
  // Credit, in-flight and FIFO bookkeeping
  // ---------------------------------------------------------------------------------------
  always_comb begin
    inflight_d = inflight_q;
    if (accept && !push) begin
      inflight_d = inflight_q + CntW'(1);
    end else if (!accept && push) begin
      inflight_d = inflight_q - CntW'(1);
    end

    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + CntW'(1);
    end else if (!push && pop) begin
      count_d = count_q - CntW'(1);
    end

    wr_ptr_d = push ? wr_ptr_q + PtrW'(1) : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + PtrW'(1) : rd_ptr_q;

    // Registered so in_ready is low while in reset. Every accepted word has a FIFO slot
    // reserved until it is popped.
    in_ready_d = ({1'b0, count_d} + {1'b0, inflight_d}) < DepthCmp;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      in_ready_q <= 1'b0;
      rom_addr_q <= '0;
      x0_q       <= '0;
      x1_q       <= '0;
      neg0_q     <= 1'b0;
      neg1_q     <= 1'b0;
      neg2_q     <= 1'b0;
      v0_q       <= 1'b0;
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      m2_q       <= '0;
      inflight_q <= '0;
      count_q    <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
    end else begin
      in_ready_q <= in_ready_d;
      // Stage 0: the ROM address holds its last value while idle.
      if (accept) begin
        rom_addr_q <= addr_fold;
        x0_q       <= x_fold;
        neg0_q     <= neg_in;
      end
      v0_q       <= accept;
      // Stage 1: wait one edge for the ROM to register its coefficients.
      x1_q       <= x0_q;
      neg1_q     <= neg0_q;
      v1_q       <= v0_q;
      // Stage 2
      m2_q       <= m_sat;
      neg2_q     <= neg1_q;
      v2_q       <= v1_q;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
    end
  end

  // Storage is not reset. The cleared pointers and count make stale entries unreachable.
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q] <= y3;
    end
  end

  assign in_ready_o  = in_ready_q;
  assign rom_addr_o  = rom_addr_q;
  assign out_valid_o = (count_q != '0);
  assign out_y_o     = out_valid_o ? mem_q[rd_ptr_q] : 20'd0;

endmodule
